// File: rtl/imem_loader_if.sv
// Byte-stream sink and instruction-RAM write port of the boot loader.
// The master side is the loader: it accepts stream bytes and drives RAM writes.
// The slave side is its environment: the byte source plus the instruction RAM.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Consumes a little-endian byte stream (16-bit word count, then 4 bytes per
// word), writes each assembled word into the instruction RAM and holds the
// CPU in reset until the whole image has been written.
module imem_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int BASE_ADDR  = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Number of words that fit between BASE_ADDR and the top of the RAM.
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned CAPACITY = DEPTH - BASE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  n_lo;       // low byte of the word count, held until HDR1
    logic [15:0] n_words;    // word count of the current image
    logic [15:0] word_cnt;   // words already written
    logic [1:0]  byte_idx;   // lane of the next data byte
    logic [23:0] shreg;      // lanes 0..2; lane 3 comes straight from the stream
    logic        accept;
    logic [15:0] hdr_n;
    logic        hdr_bad;

    assign accept  = bus.byte_valid && bus.byte_ready;
    assign hdr_n   = {bus.byte_data, n_lo};
    assign hdr_bad = (hdr_n == 16'd0) || (32'(hdr_n) > CAPACITY);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_nxt = S_HDR1;
            end
            S_HDR1: begin
                if (accept) state_nxt = hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = (word_cnt + 16'd1 == n_words) ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.imem_we    = 1'b0;
        cpu_rstn       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        unique case (state)
            S_HDR0, S_HDR1, S_DATA: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
            S_WRITE: begin
                bus.imem_we = 1'b1;
                busy        = 1'b1;
            end
            S_DONE: begin
                cpu_rstn = 1'b1;
                done     = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    // Header capture, word assembly and write address/data registers.
    // Address and data are loaded on the last byte of a word, so they are
    // stable throughout WRITE and keep their values afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_lo           <= '0;
            n_words        <= '0;
            word_cnt       <= '0;
            byte_idx       <= '0;
            shreg          <= '0;
            bus.imem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            bus.imem_wdata <= '0;
        end else begin
            unique case (state)
                S_HDR0: begin
                    if (accept) n_lo <= bus.byte_data;
                end
                S_HDR1: begin
                    if (accept) begin
                        n_words  <= hdr_n;
                        word_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        unique case (byte_idx)
                            2'd0: shreg[7:0]   <= bus.byte_data;
                            2'd1: shreg[15:8]  <= bus.byte_data;
                            2'd2: shreg[23:16] <= bus.byte_data;
                            default: begin
                                bus.imem_wdata <= {bus.byte_data, shreg};
                                bus.imem_addr  <= ADDR_WIDTH'(BASE_ADDR)
                                                + word_cnt[ADDR_WIDTH-1:0];
                            end
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=7, BASE_ADDR=0).
// A capture model records every RAM write; expected values are hand-computed.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rstn;
    logic start;
    logic cpu_rstn, busy, done, err;

    imem_loader_if #(.ADDR_WIDTH(7)) bus ();

    imem_loader #(
        .ADDR_WIDTH (7),
        .BASE_ADDR  (0)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .bus      (bus),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          we_count = 0;
    logic [6:0]  last_addr = '0;
    logic [31:0] mem [0:127];

    // Free-running edge counter and instruction-RAM capture model.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.imem_we === 1'b1) begin
            mem[bus.imem_addr] = bus.imem_wdata;
            last_addr = bus.imem_addr;
            we_count = we_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("accept_timeout", {31'd0, bus.byte_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int a;
        send_byte(w[7:0],   gap, a);
        send_byte(w[15:8],  gap, a);
        send_byte(w[23:16], gap, a);
        send_byte(w[31:24], gap, a);
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("done_timeout", {31'd0, done}, 32'd1);
        at = cyc;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {i[7:0], 8'hC3, 8'(255 - i), 8'h5A};
    endfunction

    // Guard against a hung handshake.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, a, w0;

        rstn = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_ready",    {31'd0, bus.byte_ready}, 32'd0);
        check("rst_we",       {31'd0, bus.imem_we},    32'd0);
        check("rst_addr",     {25'd0, bus.imem_addr},  32'd0);
        check("rst_wdata",    bus.imem_wdata,          32'd0);
        check("rst_cpu_rstn", {31'd0, cpu_rstn},       32'd0);
        check("rst_flags",    {29'd0, busy, done, err}, 32'd0);
        rstn = 1'b1;

        // Continuous two-word image.
        pulse_start();
        w0 = we_count;
        send_byte(8'h02, 0, t0);
        send_byte(8'h00, 0, a);
        send_word(32'h00500513, 0);
        send_word(32'h00600593, 0);
        wait_done(t1);
        check("c_latency",  t1 - t0,                12);
        check("c_addr0",    mem[0],                 32'h00500513);
        check("c_addr1",    mem[1],                 32'h00600593);
        check("c_we_count", we_count - w0,          2);
        check("c_cpu_rstn", {31'd0, cpu_rstn},      32'd1);
        check("c_busy",     {31'd0, busy},          32'd0);
        check("c_hold_addr",  {25'd0, bus.imem_addr}, 32'd1);
        check("c_hold_wdata", bus.imem_wdata,       32'h00600593);

        // Same image with 3-cycle stalls; a stray start mid-load is ignored.
        mem[0] = '0;
        mem[1] = '0;
        pulse_start();
        w0 = we_count;
        send_byte(8'h02, 3, a);
        send_byte(8'h00, 3, a);
        send_byte(8'h13, 3, a);
        check("s_ready_stall", {31'd0, bus.byte_ready}, 32'd1);
        check("s_busy_stall",  {31'd0, busy},           32'd1);
        pulse_start();
        send_byte(8'h05, 3, a);
        send_byte(8'h50, 3, a);
        send_byte(8'h00, 3, a);
        send_word(32'h00600593, 3);
        wait_done(t1);
        check("s_addr0",    mem[0],        32'h00500513);
        check("s_addr1",    mem[1],        32'h00600593);
        check("s_we_count", we_count - w0, 2);
        check("s_done",     {31'd0, done}, 32'd1);

        // Zero word count goes to ERR; a valid load recovers.
        pulse_start();
        w0 = we_count;
        send_byte(8'h00, 0, a);
        send_byte(8'h00, 0, a);
        check("z_err",      {31'd0, err},            32'd1);
        check("z_cpu_rstn", {31'd0, cpu_rstn},       32'd0);
        check("z_ready",    {31'd0, bus.byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("z_err_hold", {30'd0, err, done},      32'd2);
        check("z_we_count", we_count - w0,           0);
        pulse_start();
        send_byte(8'h01, 0, a);
        send_byte(8'h00, 0, a);
        send_word(32'hDEADBEEF, 0);
        wait_done(t1);
        check("z_addr0",    mem[0],            32'hDEADBEEF);
        check("z_recover",  {30'd0, err, done}, 32'd1);

        // Capacity bound: 129 words rejected, 128 words fill the RAM.
        pulse_start();
        send_byte(8'h81, 0, a);
        send_byte(8'h00, 0, a);
        check("b129_err", {31'd0, err}, 32'd1);
        pulse_start();
        w0 = we_count;
        send_byte(8'h80, 0, a);
        send_byte(8'h00, 0, a);
        for (int i = 0; i < 128; i++) send_word(pat(i), 0);
        wait_done(t1);
        check("b128_last_addr", {25'd0, last_addr}, 32'h7F);
        check("b128_mem0",      mem[0],             32'h00C3FF5A);
        check("b128_mem127",    mem[127],           32'h7FC3805A);
        check("b128_mem64",     mem[64],            pat(64));
        check("b128_we_count",  we_count - w0,      128);
        check("b128_done",      {30'd0, done, err}, 32'd2);

        // Reset in the middle of the second word.
        pulse_start();
        send_byte(8'h02, 0, a);
        send_byte(8'h00, 0, a);
        send_word(32'h00500513, 0);
        send_byte(8'h93, 0, a);
        send_byte(8'h05, 0, a);
        send_byte(8'h60, 0, a);
        #2;
        rstn = 1'b0;
        #1;
        check("m_ready",    {31'd0, bus.byte_ready}, 32'd0);
        check("m_addr",     {25'd0, bus.imem_addr},  32'd0);
        check("m_wdata",    bus.imem_wdata,          32'd0);
        check("m_cpu_rstn", {31'd0, cpu_rstn},       32'd0);
        check("m_flags",    {28'd0, busy, done, err, bus.imem_we}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("m_idle", {30'd0, busy, cpu_rstn}, 32'd0);
        mem[0] = '0;
        mem[1] = '0;
        pulse_start();
        send_byte(8'h02, 0, a);
        send_byte(8'h00, 0, a);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        wait_done(t1);
        check("m_addr0", mem[0], 32'h11223344);
        check("m_addr1", mem[1], 32'h55667788);

        // Reload from DONE.
        pulse_start();
        check("r_cpu_rstn_drop", {29'd0, cpu_rstn, done, busy}, 32'd1);
        send_byte(8'h01, 0, a);
        send_byte(8'h00, 0, a);
        send_byte(8'hDD, 0, a);
        send_byte(8'hCC, 0, a);
        send_byte(8'hBB, 0, a);
        send_byte(8'hAA, 0, a);
        wait_done(t1);
        check("r_addr0", mem[0],                     32'hAABBCCDD);
        check("r_done",  {30'd0, cpu_rstn, done},    32'd3);
        check("r_addr1_kept", mem[1],                32'h55667788);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
